// File: rtl/if_fetch_if.sv
// Memory-side bus of the instruction-fetch stage: one word-read request
// (req/addr, held until done) and a one-cycle done pulse carrying the word.
// Signal names keep the direction suffix as seen from the fetch stage.
interface if_fetch_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_done_in;
   logic [31:0] mem_data_in;

   // Fetch stage side
   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_done_in,
      input  mem_data_in
   );

   // Memory controller side
   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_done_in,
      output mem_data_in
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Reads the aligned word at pc_in through the memory
// bus, hands {pc, inst} to the IF/ID latch and keeps stall_req_o high so the PC
// register holds until the word is accepted. A redirect while a read is in
// flight marks the returning word as stale so it is dropped.
// Optional feature: define ICACHE_EN for a direct-mapped one-word-per-line
// instruction cache (ICACHE_LINES entries) that serves hits from IDLE in a
// single cycle. Without ICACHE_EN every fetch goes to memory.
module if_fetch #(
   parameter int unsigned ICACHE_LINES = 256,
   parameter int unsigned STALL_W      = 6
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic [STALL_W-1:0] stall_in,
   input  logic               jump_enable,
   input  logic [31:0]        pc_in,
   output logic               stall_req_o,
   if_fetch_if.master         mem,
   output logic [31:0]        if_pc_o,
   output logic [31:0]        if_inst_o,
   output logic               if_valid_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        flush_q, flush_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;

   logic [31:0] pc_aligned;
   logic        go;
   logic        done_acc;
   logic        deliver_mem;
   logic        idle_hit;
   logic [31:0] hit_data;

   assign pc_aligned = {pc_in[31:2], 2'b00};
   // A new fetch may start only when nothing redirects or holds IF/ID.
   assign go          = rdy_in && !jump_enable && !stall_in[1];
   assign done_acc    = rdy_in && (state_q == S_WAIT) && mem.mem_done_in;
   // A word returning in the same cycle as a redirect is dropped directly.
   assign deliver_mem = done_acc && !flush_q && !jump_enable;

`ifdef ICACHE_EN
   localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [31:0]             line_data_q [ICACHE_LINES];
   logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] line_vld_q;

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] wr_idx;
   logic             hit;

   assign rd_idx   = pc_in[2+IDX_W-1:2];
   assign rd_tag   = pc_in[31:2+IDX_W];
   assign wr_idx   = mem_addr_q[2+IDX_W-1:2];
   assign hit      = line_vld_q[rd_idx] && (line_tag_q[rd_idx] == rd_tag);
   assign hit_data = line_data_q[rd_idx];
   assign idle_hit = (state_q == S_IDLE) && go && hit;

   // Line valid bits: cleared only by reset, set by every accepted memory return.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         line_vld_q <= '0;
      end else if (done_acc) begin
         line_vld_q[wr_idx] <= 1'b1;
      end
   end

   // Line payload: every accepted return fills its line, stale or not.
   always_ff @(posedge clk_in) begin
      if (done_acc) begin
         line_data_q[wr_idx] <= mem.mem_data_in;
         line_tag_q[wr_idx]  <= mem_addr_q[31:2+IDX_W];
      end
   end
`else
   assign hit_data = '0;
   assign idle_hit = 1'b0;
`endif

   // Bits of the inputs and configuration this stage does not look at.
   localparam logic [31:0] LINES_V = 32'(ICACHE_LINES);
   logic unused_ok;
   assign unused_ok = ^{pc_in[1:0], stall_in[STALL_W-1:2], stall_in[0], LINES_V[0]};

   // The PC may only move on the edge that latches an instruction.
   assign stall_req_o = !(deliver_mem || idle_hit);

   // Next-state and output logic; everything holds while rdy_in is low.
   always_comb begin
      state_d    = state_q;
      flush_d    = flush_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;

      if (rdy_in) begin
         // A delivered word lives one cycle unless IF/ID is held; a redirect always kills it.
         if (jump_enable || !stall_in[1]) begin
            if_valid_d = 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (idle_hit) begin
                  if_pc_d    = pc_aligned;
                  if_inst_d  = hit_data;
                  if_valid_d = 1'b1;
               end else if (go) begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_aligned;
                  state_d    = S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem.mem_done_in) begin
                  mem_req_d = 1'b0;
                  state_d   = S_IDLE;
                  flush_d   = 1'b0;
                  if (deliver_mem) begin
                     if_pc_d    = mem_addr_q;
                     if_inst_d  = mem.mem_data_in;
                     if_valid_d = 1'b1;
                  end else if (flush_q) begin
                     if_valid_d = 1'b0;
                  end
               end else if (jump_enable) begin
                  flush_d = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= S_IDLE;
         flush_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_q    <= flush_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign mem.mem_req_o  = mem_req_q;
   assign mem.mem_addr_o = mem_addr_q;
   assign if_pc_o        = if_pc_q;
   assign if_inst_o      = if_inst_q;
   assign if_valid_o     = if_valid_q;

endmodule
